// File: rtl/surf_sysref_check.sv
// surf_sysref_check: measures sync_i to PL SYSREF offset and sync_i period.
// Define SURF_SYSREF_ERRCNT_EN to build the saturating error counter.
module surf_sysref_check #(
   parameter int EXPECTED_PERIOD = 48,
   parameter int MAX_WAIT        = 63
) (
   input  logic        aclk_i,
   input  logic        aclk_rst_i,
   input  logic        enable_i,
   input  logic        clear_i,
   input  logic        sync_i,
   input  logic        pl_sysref_i,
   output logic [5:0]  offset_o,
   output logic        offset_valid_o,
   output logic        locked_o,
   output logic        offset_err_o,
   output logic        period_err_o,
   output logic        timeout_o,
   output logic [15:0] err_count_o
);

   typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

   localparam logic [5:0] MAX_W = 6'(MAX_WAIT);
   localparam logic [7:0] EXP_P = 8'(EXPECTED_PERIOD);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] count;
   logic       sysref_prev;
   logic       sys_edge;
   logic       cap_now;
   logic [5:0] cap_val;
   logic       to_now;
   logic       oerr_now;
   logic [5:0] ref_off;
   logic       ref_ok;
   logic       en_prev;
   logic [7:0] per_cnt;
   logic       per_armed;
   logic       per_restart;
   logic       per_now;

   assign sys_edge = pl_sysref_i && !sysref_prev;

   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable_i) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nxt = ARMED;
            ARMED:   if (sync_i && !sys_edge) state_nxt = MEASURE;
            MEASURE: if (sys_edge || count == MAX_W) state_nxt = ARMED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      cap_now = 1'b0;
      cap_val = count;
      to_now  = 1'b0;
      if (enable_i) begin
         unique case (state)
            ARMED: begin
               if (sync_i && sys_edge) begin
                  cap_now = 1'b1;
                  cap_val = '0;
               end
            end
            MEASURE: begin
               if (sys_edge)            cap_now = 1'b1;
               else if (count == MAX_W) to_now  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign oerr_now = cap_now && ref_ok && (cap_val != ref_off) && !clear_i;

   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         count       <= '0;
         sysref_prev <= 1'b0;
      end else begin
         sysref_prev <= pl_sysref_i;
         if (state == ARMED && state_nxt == MEASURE)
            count <= 6'd1;
         else if (state == MEASURE && state_nxt == MEASURE)
            count <= count + 6'd1;
         else
            count <= '0;
      end
   end

   // clear_i takes priority over any error raised in the same cycle
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         offset_o       <= '0;
         offset_valid_o <= 1'b0;
         locked_o       <= 1'b0;
         offset_err_o   <= 1'b0;
         period_err_o   <= 1'b0;
         timeout_o      <= 1'b0;
         ref_off        <= '0;
         ref_ok         <= 1'b0;
      end else begin
         offset_valid_o <= cap_now;
         if (cap_now) offset_o <= cap_val;
         if (clear_i) begin
            locked_o     <= 1'b0;
            offset_err_o <= 1'b0;
            period_err_o <= 1'b0;
            timeout_o    <= 1'b0;
            ref_off      <= '0;
            ref_ok       <= 1'b0;
         end else begin
            if (cap_now && !ref_ok) begin
               ref_ok   <= 1'b1;
               ref_off  <= cap_val;
               locked_o <= 1'b1;
            end
            if (oerr_now) begin
               offset_err_o <= 1'b1;
               locked_o     <= 1'b0;
            end
            if (to_now)  timeout_o    <= 1'b1;
            if (per_now) period_err_o <= 1'b1;
         end
      end
   end

   assign per_restart = enable_i && (!en_prev || clear_i);
   assign per_now     = enable_i && !per_restart && sync_i &&
                        per_armed && (per_cnt != EXP_P);

   // first sync after restart only starts the interval count
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         en_prev   <= 1'b0;
         per_cnt   <= '0;
         per_armed <= 1'b0;
      end else begin
         en_prev <= enable_i;
         if (per_restart) begin
            per_cnt   <= '0;
            per_armed <= 1'b0;
         end else if (enable_i) begin
            if (sync_i) begin
               per_cnt   <= 8'd1;
               per_armed <= 1'b1;
            end else if (per_cnt != 8'hFF) begin
               per_cnt <= per_cnt + 8'd1;
            end
         end
      end
   end

`ifdef SURF_SYSREF_ERRCNT_EN
   logic [15:0] err_cnt;

   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i || clear_i)
         err_cnt <= '0;
      else if ((oerr_now || to_now || per_now) && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end

   assign err_count_o = err_cnt;
`else
   assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_surf_sysref_check.sv
// Directed bench for surf_sysref_check with a time-stamp based reference model.
`timescale 1ns/1ps
module tb_surf_sysref_check;

   localparam int EXPECTED = 48;
   localparam int MAXW     = 63;

   logic        aclk = 1'b0;
   logic        rst  = 1'b1;
   logic        en   = 1'b0;
   logic        clr  = 1'b0;
   logic        sync = 1'b0;
   logic        sys  = 1'b0;
   logic [5:0]  offset_o;
   logic        offset_valid_o;
   logic        locked_o;
   logic        offset_err_o;
   logic        period_err_o;
   logic        timeout_o;
   logic [15:0] err_count_o;

   int errors = 0;
   int checks = 0;

   always #5 aclk = ~aclk;

   surf_sysref_check #(.EXPECTED_PERIOD(EXPECTED), .MAX_WAIT(MAXW)) dut (
      .aclk_i        (aclk),
      .aclk_rst_i    (rst),
      .enable_i      (en),
      .clear_i       (clr),
      .sync_i        (sync),
      .pl_sysref_i   (sys),
      .offset_o      (offset_o),
      .offset_valid_o(offset_valid_o),
      .locked_o      (locked_o),
      .offset_err_o  (offset_err_o),
      .period_err_o  (period_err_o),
      .timeout_o     (timeout_o),
      .err_count_o   (err_count_o)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // model: measurement tracked as a start time stamp, period as time deltas
   int  t = 0;
   bit  started = 0;
   bit  m_prev = 0, m_en_prev = 0;
   bit  meas = 0;
   int  ts = 0;
   bit  have_sync = 0;
   int  last_sync = 0;
   bit  ref_ok = 0;
   int  ref_v = 0;
   int  e_off = 0, e_cnt = 0;
   bit  e_valid = 0, e_locked = 0, e_oerr = 0, e_perr = 0, e_to = 0;
   bit  edg, armed, ev;
   int  cap, iv;

   always @(posedge aclk) begin
      t = t + 1;
      started = 1;
      if (rst) begin
         meas = 0; have_sync = 0; ref_ok = 0; ref_v = 0;
         e_off = 0; e_cnt = 0; e_valid = 0; e_locked = 0;
         e_oerr = 0; e_perr = 0; e_to = 0;
      end else begin
         edg   = sys && !m_prev;
         armed = en && m_en_prev;
         cap   = -1;
         ev    = 0;
         e_valid = 0;
         if (clr) begin
            e_oerr = 0; e_perr = 0; e_to = 0; e_locked = 0; ref_ok = 0;
         end
         if (!en) begin
            meas = 0;
         end else if (meas) begin
            if (edg) begin
               cap = t - ts; meas = 0;
            end else if (t - ts == MAXW) begin
               meas = 0;
               if (!clr) begin e_to = 1; ev = 1; end
            end
         end else if (armed && sync) begin
            if (edg) cap = 0;
            else begin meas = 1; ts = t; end
         end
         if (cap >= 0) begin
            e_off = cap; e_valid = 1;
            if (!clr) begin
               if (!ref_ok) begin
                  ref_ok = 1; ref_v = cap; e_locked = 1;
               end else if (cap != ref_v) begin
                  e_oerr = 1; e_locked = 0; ev = 1;
               end
            end
         end
         if (en) begin
            if (!m_en_prev || clr) begin
               have_sync = 0;
            end else if (sync) begin
               iv = t - last_sync;
               if (iv > 255) iv = 255;
               if (have_sync && iv != EXPECTED) begin e_perr = 1; ev = 1; end
               have_sync = 1; last_sync = t;
            end
         end
`ifdef SURF_SYSREF_ERRCNT_EN
         if (clr) e_cnt = 0;
         else if (ev && e_cnt < 65535) e_cnt = e_cnt + 1;
`endif
      end
      m_prev    = rst ? 1'b0 : sys;
      m_en_prev = rst ? 1'b0 : en;
   end

   always @(negedge aclk) begin
      if (started) begin
         chk("offset_o", 32'(offset_o), 32'(e_off));
         chk("offset_valid_o", 32'(offset_valid_o), 32'(e_valid));
         chk("locked_o", 32'(locked_o), 32'(e_locked));
         chk("offset_err_o", 32'(offset_err_o), 32'(e_oerr));
         chk("period_err_o", 32'(period_err_o), 32'(e_perr));
         chk("timeout_o", 32'(timeout_o), 32'(e_to));
         chk("err_count_o", 32'(err_count_o), 32'(e_cnt));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // one sync period; d < 0 means no SYSREF edge in this period
   task automatic sync_cycle(input int d, input int period);
      for (int i = 0; i < period; i++) begin
         sync = (i == 0);
         sys  = (d >= 0 && i >= d && i < d + 4);
         step(1);
      end
      sync = 1'b0;
      sys  = 1'b0;
   endtask

   task automatic pin(input string nm, input logic [31:0] act,
                      input int mdl, input int lit);
      chk({nm, " dut"}, act, 32'(lit));
      chk({nm, " model"}, 32'(mdl), 32'(lit));
   endtask

   initial begin
      int n_cnt1, n_cnt2;
`ifdef SURF_SYSREF_ERRCNT_EN
      n_cnt1 = 1;
      n_cnt2 = 2;
`else
      n_cnt1 = 0;
      n_cnt2 = 0;
`endif
      step(3);
      pin("rst offset", 32'(offset_o), e_off, 0);
      pin("rst locked", 32'(locked_o), int'(e_locked), 0);
      pin("rst valid", 32'(offset_valid_o), int'(e_valid), 0);
      pin("rst errcnt", 32'(err_count_o), e_cnt, 0);

      rst = 1'b0;
      en  = 1'b1;
      step(3);
      repeat (4) sync_cycle(7, 48);
      pin("lock offset", 32'(offset_o), e_off, 7);
      pin("lock locked", 32'(locked_o), int'(e_locked), 1);
      pin("lock oerr", 32'(offset_err_o), int'(e_oerr), 0);
      pin("lock perr", 32'(period_err_o), int'(e_perr), 0);

      sync_cycle(8, 48);
      pin("slip oerr", 32'(offset_err_o), int'(e_oerr), 1);
      pin("slip locked", 32'(locked_o), int'(e_locked), 0);
      pin("slip errcnt", 32'(err_count_o), e_cnt, n_cnt1);

      sync_cycle(7, 47);
      sync_cycle(7, 48);
      pin("short perr", 32'(period_err_o), int'(e_perr), 1);
      pin("short errcnt", 32'(err_count_o), e_cnt, n_cnt2);

      clr = 1'b1;
      step(1);
      clr = 1'b0;
      pin("clr oerr", 32'(offset_err_o), int'(e_oerr), 0);
      pin("clr perr", 32'(period_err_o), int'(e_perr), 0);
      pin("clr locked", 32'(locked_o), int'(e_locked), 0);
      pin("clr errcnt", 32'(err_count_o), e_cnt, 0);
      repeat (2) sync_cycle(7, 48);
      pin("relock", 32'(locked_o), int'(e_locked), 1);

      sync_cycle(-1, 70);
      pin("timeout", 32'(timeout_o), int'(e_to), 1);
      sync_cycle(0, 48);
      pin("zero offset", 32'(offset_o), e_off, 0);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(5);

      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(4);
      rst = 1'b1;
      sys = 1'b1;
      step(2);
      pin("midrst valid", 32'(offset_valid_o), int'(e_valid), 0);
      pin("midrst offset", 32'(offset_o), e_off, 0);
      pin("midrst timeout", 32'(timeout_o), int'(e_to), 0);
      rst = 1'b0;
      sys = 1'b0;
      step(3);
      repeat (2) sync_cycle(7, 48);
      pin("post rst offset", 32'(offset_o), e_off, 7);

      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(2);
      en = 1'b0;
      step(1);
      sys = 1'b1;
      step(3);
      sys = 1'b0;
      step(2);
      pin("en drop offset", 32'(offset_o), e_off, 7);
      en = 1'b1;
      step(2);
      repeat (2) sync_cycle(7, 48);
      pin("re-enable offset", 32'(offset_o), e_off, 7);
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/surf_sysref_check.md
SURF_SYSREF_CHECK -- requirements
Module: surf_sysref_check

Interface
REQ-001 Parameter EXPECTED_PERIOD, default 48, nominal aclk cycles between successive sync_i pulses.
REQ-002 Parameter MAX_WAIT, default 63, last count value (aclk cycles after sync_i) before a measurement times out.
REQ-003 aclk_i  in  1  sole clock, 375 MHz.
REQ-004 aclk_rst_i  in  1  reset; synchronous, active-high.
REQ-005 enable_i  in  1  arms measurement; static, aclk domain.
REQ-006 clear_i  in  1  single-cycle pulse; clears sticky flags and the reference offset.
REQ-007 sync_i  in  1  single-cycle aclk sync pulse from the sync generator.
REQ-008 pl_sysref_i  in  1  PL SYSREF, already synchronized to aclk_i.
REQ-009 offset_o  out  6  latched sync_i-to-SYSREF-rising-edge offset, in aclk cycles.
REQ-010 offset_valid_o  out  1  one-cycle pulse when offset_o updates.
REQ-011 locked_o  out  1  reference offset captured and no offset_err since the last clear.
REQ-012 offset_err_o, period_err_o, timeout_o  out  1 each  sticky error flags.
REQ-013 err_count_o  out  16  error counter (see Configuration).

Function
REQ-014 Rising edge of pl_sysref_i SHALL be detected against a registered copy: edge = pl_sysref_i && !prev.
REQ-015 FSM states: IDLE, ARMED, MEASURE. IDLE -> ARMED when enable_i=1.
REQ-016 ARMED: sync_i -> MEASURE with count=1; sync_i and edge in the same cycle -> offset 0 captured, stay ARMED.
REQ-017 MEASURE: edge -> offset_o=count, offset_valid_o pulses next cycle, return to ARMED.
REQ-018 MEASURE: count increments per cycle; sync_i in MEASURE is ignored for offset purposes.
REQ-019 MEASURE: count==MAX_WAIT with no edge -> timeout_o set, return to ARMED, offset_o unchanged.
REQ-020 First capture after reset/clear stores the reference offset and sets locked_o; each later capture != reference sets offset_err_o and clears locked_o; reference is retained.
REQ-021 enable_i=0 in any state -> IDLE next cycle; offset_o, flags, and reference retained.
REQ-022 Period checker runs independently of the FSM while enable_i=1: counts aclk cycles between sync_i pulses, saturating at 255; after the second sync_i, interval != EXPECTED_PERIOD -> period_err_o set.
REQ-023 The period checker SHALL restart on enable_i rising edge and on clear_i, ignoring the first interval after restart.
REQ-024 clear_i clears all sticky flags, locked_o, and the reference; when clear_i coincides with a new error, clear_i wins.
REQ-025 All outputs SHALL be registered; latency from edge to offset_valid_o is 1 cycle.

Reset
REQ-026 aclk_rst_i=1: FSM=IDLE; all counters, flags, offset_o, and reference =0; locked_o=0; offset_valid_o=0.
REQ-027 Reset mid-MEASURE abandons the measurement with no offset_valid_o pulse.

Configuration
REQ-028 Macro SURF_SYSREF_ERRCNT_EN defined: err_count_o is a 16-bit saturating count (stops at 65535) of offset_err, period_err, and timeout events (+1 per cycle with any event), cleared by clear_i/reset.
REQ-029 Macro SURF_SYSREF_ERRCNT_EN undefined: err_count_o is tied to 0 and no counter logic is instantiated.

Verification
REQ-030 enable=1; sync_i every 48 cycles; SYSREF rise 7 cycles after each sync -> offset_o=7, locked_o=1, no errors.
REQ-031 After lock at 7, one SYSREF arrives at offset 8 -> offset_err_o=1, locked_o=0, err_count_o=1 (macro on) or 0 (macro off).
REQ-032 sync_i interval of 47 once -> period_err_o=1; then clear_i -> all flags 0, locked_o re-asserts on the next capture.
REQ-033 No SYSREF after sync_i -> timeout_o set 63 cycles after sync_i; sync_i and SYSREF edge in the same cycle -> offset_o=0.
REQ-034 aclk_rst_i asserted at MEASURE count 5 -> no offset_valid_o pulse, all outputs 0; enable_i dropped mid-measure -> IDLE, offset_o retained.
